// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column scan, press/release debounce, one-clk key strobe.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes every REPEAT_TICKS ticks while a key is held.
module keypad_scanner #(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);
    localparam int TICK_W = $clog2(CLK_DIV) + 1;
    localparam int DB_W   = $clog2(DEBOUNCE_TICKS) + 1;

    if (CLK_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE_DB} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_row_meta;
    logic [3:0]        r_row_s;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [3:0]        r_col;
    logic [3:0]        w_col_next;
    logic [3:0]        r_cap_row;
    logic [3:0]        w_cap_row_next;
    logic [1:0]        r_cap_col;
    logic [1:0]        w_cap_col_next;
    logic [DB_W-1:0]   r_stable_cnt;
    logic [DB_W-1:0]   w_stable_next;
    logic [DB_W-1:0]   w_stable_inc;
    logic [3:0]        r_key_code;
    logic [3:0]        w_code_next;
    logic              r_key_valid;
    logic              w_valid_next;
    logic              r_key_pressed;
    logic              w_pressed_next;
    logic [1:0]        w_col_idx;
    logic [1:0]        w_row_idx;
    logic              w_rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'hF;
            r_row_s    <= 4'hF;
            r_tick_cnt <= '0;
        end else begin
            r_row_meta <= row;
            r_row_s    <= r_row_meta;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick       = (r_tick_cnt == TICK_W'(CLK_DIV - 1));
    assign w_stable_inc = r_stable_cnt + DB_W'(1);

    // Descending loops leave the lowest-index low bit as the winner.
    always_comb begin
        w_col_idx = 2'd0;
        w_row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_col[i])     w_col_idx = 2'(i);
            if (!r_cap_row[i]) w_row_idx = 2'(i);
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS) + 1;

    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_next;
    logic [RPT_W-1:0] w_rpt_inc;

    assign w_rpt_inc = r_rpt_cnt + RPT_W'(1);

    always_comb begin
        w_rpt_next = r_rpt_cnt;
        w_rpt_fire = 1'b0;
        if (r_state != PRESSED) begin
            w_rpt_next = '0;
        end else if (w_tick) begin
            if (r_row_s == 4'hF) begin
                w_rpt_next = '0;
            end else if (w_rpt_inc == RPT_W'(REPEAT_TICKS)) begin
                w_rpt_next = '0;
                w_rpt_fire = 1'b1;
            end else begin
                w_rpt_next = w_rpt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rpt_cnt <= '0;
        else        r_rpt_cnt <= w_rpt_next;
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_col_next     = r_col;
        w_cap_row_next = r_cap_row;
        w_cap_col_next = r_cap_col;
        w_stable_next  = r_stable_cnt;
        w_code_next    = r_key_code;
        w_valid_next   = r_key_valid;
        w_pressed_next = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (r_row_s == 4'hF) begin
                        w_col_next = {r_col[2:0], r_col[3]};
                    end else begin
                        w_cap_row_next = r_row_s;
                        w_cap_col_next = w_col_idx;
                        w_stable_next  = '0;
                        w_state_next   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (r_row_s == r_cap_row) begin
                        w_stable_next = w_stable_inc;
                        if (w_stable_inc == DB_W'(DEBOUNCE_TICKS)) begin
                            w_code_next    = {w_row_idx, r_cap_col};
                            w_valid_next   = 1'b1;
                            w_pressed_next = 1'b1;
                            w_state_next   = PRESSED;
                        end
                    end else begin
                        w_state_next = SCAN;
                    end
                end
                PRESSED: begin
                    if (r_row_s == 4'hF) begin
                        w_stable_next = '0;
                        w_state_next  = RELEASE_DB;
                    end else if (w_rpt_fire) begin
                        w_pressed_next = 1'b1;
                    end
                end
                RELEASE_DB: begin
                    if (r_row_s == 4'hF) begin
                        w_stable_next = w_stable_inc;
                        if (w_stable_inc == DB_W'(DEBOUNCE_TICKS)) begin
                            w_valid_next = 1'b0;
                            w_col_next   = {r_col[2:0], r_col[3]};
                            w_state_next = SCAN;
                        end
                    end else begin
                        w_state_next = PRESSED;
                    end
                end
                default: w_state_next = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SCAN;
            r_col         <= 4'b1110;
            r_cap_row     <= 4'hF;
            r_cap_col     <= 2'd0;
            r_stable_cnt  <= '0;
            r_key_code    <= 4'h0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_col         <= w_col_next;
            r_cap_row     <= w_cap_row_next;
            r_cap_col     <= w_cap_col_next;
            r_stable_cnt  <= w_stable_next;
            r_key_code    <= w_code_next;
            r_key_valid   <= w_valid_next;
            r_key_pressed <= w_pressed_next;
        end
    end

    assign col         = r_col;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_pressed = r_key_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical 4x4 matrix model drives the rows from the scanned column,
// and a queue of expected key codes is matched against every key_pressed strobe.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int CLK_DIV = 4;
    localparam int DB      = 3;
    localparam int RPT     = 5;

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  code;
        logic [3:0]  colp;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;
    logic [15:0] keys = '0;
    int          total = 0;
    int          bad = 0;
    int          strobes = 0;
    int          tb_cnt;
    logic [3:0]  exp_q[$];
    logic [3:0]  e_code;
    logic        prev_pressed = 1'b0;

    keypad_scanner #(
        .CLK_DIV(CLK_DIV),
        .DEBOUNCE_TICKS(DB),
        .REPEAT_TICKS(RPT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == CLK_DIV - 1) ? 0 : tb_cnt + 1;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [3:0] rot(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && key_pressed) begin
            strobes++;
            chk("strobe_gap", {31'd0, prev_pressed}, 32'd0);
            chk("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e_code = exp_q.pop_front();
                chk("strobe_code", {28'd0, key_code}, {28'd0, e_code});
                chk("strobe_valid", {31'd0, key_valid}, 32'd1);
                $display("strobe: code=%h expected=%h", key_code, e_code);
            end
        end
        prev_pressed = key_pressed;
    end

    task automatic wait_tick();
        do @(negedge clk); while (tb_cnt != CLK_DIV - 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            if (key_valid) break;
        end
        chk(name, {31'd0, key_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs[6];
        logic [3:0] scan_exp[4];
        int         s0;
        int         n_exp;

        vecs[0] = '{16'h0200, 4'h9, 4'b1101};
        vecs[1] = '{16'h1010, 4'h4, 4'b1110};
        vecs[2] = '{16'h0040, 4'h6, 4'b1011};
        vecs[3] = '{16'h8000, 4'hF, 4'b0111};
        vecs[4] = '{16'h0001, 4'h0, 4'b1110};
        vecs[5] = '{16'h0808, 4'h3, 4'b0111};
        scan_exp[0] = 4'b1101;
        scan_exp[1] = 4'b1011;
        scan_exp[2] = 4'b0111;
        scan_exp[3] = 4'b1110;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col", {28'd0, col}, 32'hE);
        chk("rst_code", {28'd0, key_code}, 32'h0);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_pressed", {31'd0, key_pressed}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            wait_tick();
            chk("scan_col", {28'd0, col}, {28'd0, scan_exp[i]});
            chk("scan_valid", {31'd0, key_valid}, 32'd0);
            chk("scan_code", {28'd0, key_code}, 32'h0);
        end

        // Row 2 held from col 0: rotate, capture at col 1, accept three ticks later.
        keys = 16'h0200;
        exp_q.push_back(4'h9);
        wait_tick();
        chk("press_col1", {28'd0, col}, 32'hD);
        repeat (3) wait_tick();
        chk("press_not_yet", {31'd0, key_valid}, 32'd0);
        wait_tick();
        chk("press_strobe", {31'd0, key_pressed}, 32'd1);
        chk("press_valid", {31'd0, key_valid}, 32'd1);
        chk("press_code", {28'd0, key_code}, 32'h9);
        $display("press: code=%h valid=%b", key_code, key_valid);
        keys = '0;
        repeat (3) wait_tick();
        chk("release_hold", {31'd0, key_valid}, 32'd1);
        wait_tick();
        chk("release_valid", {31'd0, key_valid}, 32'd0);
        chk("release_col2", {28'd0, col}, 32'hB);

        // Bounce at col 3: one tick low, then high.
        wait_tick();
        chk("bounce_col3", {28'd0, col}, 32'h7);
        keys = 16'h0008;
        wait_tick();
        keys = '0;
        wait_tick();
        chk("bounce_no_rotate", {28'd0, col}, 32'h7);
        chk("bounce_valid", {31'd0, key_valid}, 32'd0);
        chk("bounce_code", {28'd0, key_code}, 32'h9);
        wait_tick();
        chk("bounce_rescan", {28'd0, col}, 32'hE);
        $display("bounce: col=%b code=%h", col, key_code);

        for (int v = 0; v < 6; v++) begin
            keys = vecs[v].mask;
            exp_q.push_back(vecs[v].code);
            wait_valid("vec_press");
            chk("vec_code", {28'd0, key_code}, {28'd0, vecs[v].code});
            chk("vec_col", {28'd0, col}, {28'd0, vecs[v].colp});
            keys = '0;
            repeat (3) wait_tick();
            chk("vec_hold", {31'd0, key_valid}, 32'd1);
            wait_tick();
            chk("vec_release", {31'd0, key_valid}, 32'd0);
            chk("vec_next_col", {28'd0, col}, {28'd0, rot(vecs[v].colp)});
            $display("vector %0d: mask=%h code=%h col=%b", v, vecs[v].mask, key_code, col);
        end

        // Release glitch: two high ticks, then pressed again, must not restrobe.
        keys = 16'h0040;
        exp_q.push_back(4'h6);
        wait_valid("glitch_press");
        keys = '0;
        wait_tick();
        chk("glitch_t1", {31'd0, key_valid}, 32'd1);
        wait_tick();
        chk("glitch_t2", {31'd0, key_valid}, 32'd1);
        keys = 16'h0040;
        wait_tick();
        chk("glitch_back", {31'd0, key_valid}, 32'd1);
        keys = '0;
        repeat (3) wait_tick();
        chk("glitch_hold", {31'd0, key_valid}, 32'd1);
        wait_tick();
        chk("glitch_release", {31'd0, key_valid}, 32'd0);
        $display("glitch: valid=%b code=%h", key_valid, key_code);

        // Long hold of key F: repeat strobes only when the repeat feature is built in.
        s0 = strobes;
        keys = 16'h8000;
        exp_q.push_back(4'hF);
        n_exp = 1;
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back(4'hF);
        exp_q.push_back(4'hF);
        n_exp = 3;
`endif
        wait_valid("hold_press");
        for (int k = 1; k <= 12; k++) begin
            wait_tick();
`ifdef KEYPAD_REPEAT_EN
            chk("hold_strobe", {31'd0, key_pressed}, {31'd0, (k % RPT) == 0});
`else
            chk("hold_strobe", {31'd0, key_pressed}, 32'd0);
`endif
        end
        keys = '0;
        repeat (4) wait_tick();
        chk("hold_release", {31'd0, key_valid}, 32'd0);
        chk("hold_count", strobes - s0, n_exp);
        $display("hold: strobes=%0d expected=%0d", strobes - s0, n_exp);

        // Reset while debouncing key 0.
        keys = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            if (col == 4'b1110) break;
            wait_tick();
        end
        repeat (2) wait_tick();
        chk("db_not_yet", {31'd0, key_valid}, 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_col", {28'd0, col}, 32'hE);
        chk("mid_rst_code", {28'd0, key_code}, 32'h0);
        chk("mid_rst_valid", {31'd0, key_valid}, 32'd0);
        chk("mid_rst_pressed", {31'd0, key_pressed}, 32'd0);
        keys = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_tick();
        chk("post_rst_col", {28'd0, col}, 32'hD);
        $display("reset: col=%b code=%h valid=%b", col, key_code, key_valid);

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
